move_sequencer: RTL and testbench
=================================

// Module: move_sequencer
// PURPOSE
//  Sequences decoded TTA move/literal instructions from decodeunit onto the transport
//  interconnect: reads the source socket, then writes the destination socket.
//  Owns the read/write strobes and the literal half-word merge.
//  Detects hung sockets via ack timeout.
//  Sits between decodeunit outputs and the register/FU socket bus.
// PARAMETERS
//  DW       24  transport data width (two LW halves)
//  AW       7   socket address width (src/dest)
//  LW       12  literal width; DW == 2*LW
//  TIMEOUT  15  max cycles waiting for rd_ack/wr_ack before error (1..255)
// PORTS
//  clk        in   1    clock, all state on rising edge
//  rst        in   1    synchronous reset, active-high
//  in_valid   in   1    decoded instruction valid (from decodeunit valid)
//  in_ready   out  1    sequencer accepts instruction this cycle
//  in_lit_mv  in   1    1 = literal load, 0 = move
//  in_src     in   AW   source socket
//  in_dest    in   AW   destination socket
//  in_hl      in   1    literal half: 1 = high [DW-1:LW], 0 = low [LW-1:0]
//  in_lit     in   LW   literal value
//  rd_en      out  1    source read strobe, held until rd_ack
//  rd_addr    out  AW   source socket address
//  rd_data    in   DW   source data, valid when rd_ack=1
//  rd_ack     in   1    source read complete
//  wr_en      out  1    destination write strobe, held until wr_ack
//  wr_addr    out  AW   destination socket address
//  wr_data    out  DW   write data
//  wr_mask    out  2    half enables {high,low}
//  wr_ack     in   1    destination write complete
//  err        out  1    sticky ack-timeout error
//  moves_done out  16   completed transfers count
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1; rd_en=wr_en=0; rd_addr=wr_addr=0; wr_data=0;
//   wr_mask=0; err=0; moves_done=0; timeout counter=0. Reset mid-transfer aborts it;
//   strobes low from the first cycle after the reset edge.
//  States: IDLE, RD, WR, ERR.
//  Accept = in_valid & in_ready. in_ready = (IDLE) | (WR & wr_ack); 0 in RD and ERR.
//  On accept: latch all in_* fields; move -> RD; literal -> WR (no read).
//  RD: rd_en=1, rd_addr=latched src. On rd_ack: wr_data<=rd_data, wr_mask<=2'b11, -> WR.
//  Literal: wr_data={in_lit,in_lit}; wr_mask=2'b10 if hl=1 else 2'b01.
//   The target merges only the masked half.
//  WR: wr_en=1, wr_addr=latched dest. On wr_ack: moves_done+=1 (wraps 0xFFFF->0).
//   Same-cycle accept (back-to-back) -> RD/WR of the new instruction; otherwise -> IDLE.
//  Min latency accept->wr_ack: move 2 cycles, literal 1 cycle.
//  rd_en/wr_en rise the cycle after entry to RD/WR.
//  Timeout counter clears on state entry and increments each RD/WR cycle without ack.
//   When count == TIMEOUT with no ack -> ERR.
//   ERR: err=1, strobes 0, in_ready=0; exit only by rst.
//  An ack arriving on the TIMEOUT cycle wins; there is no error.
//  Acks outside RD/WR (stray) are ignored.
//  rd_ack and wr_ack high together: only the ack for the current state is used.
//  src==dest move is legal: read completes, then write.
// TESTING
//  Move 0x01->0x7F, rd_ack after 1 cycle with rd_data=0xABCDEF, wr_ack immediate
//   -> wr_addr=0x7F, wr_data=0xABCDEF, wr_mask=11, moves_done=1.
//  Literal 0xFFF high -> 0x00 (instr 0x600FFF)
//   -> no rd_en, wr_data=0xFFFFFF, wr_mask=10, wr_addr=0x00.
//  Back-to-back: literal low 0x123 -> 0x05, then move 0x05->0x06, valid held
//   -> second accepted in wr_ack cycle, no IDLE bubble, moves_done=2.
//  Hold rd_ack=0 for 15 cycles after rd_en -> err=1, rd_en=0, in_ready=0
//   until rst; ack on cycle 15 -> no error.
//  Assert rst during WR with wr_en=1 -> next cycle wr_en=0, in_ready=1, moves_done=0.
//  Preload moves_done=0xFFFF via 65535 literal loads, one more -> wraps to 0x0000.

Source files
------------

// File: rtl/move_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : move_sequencer
//  Description : Sequences decoded TTA move / literal instructions onto the
//                transport interconnect. A move reads the source socket and
//                then writes the destination socket. A literal skips the read
//                and writes one masked half-word. A socket that never
//                acknowledges is caught by an ack timeout, which parks the
//                sequencer in a sticky error state until reset.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                in_*            - decoded instruction + valid/ready handshake
//                rd_*            - source socket read strobe/address/data/ack
//                wr_*            - destination write strobe/address/data/mask/ack
//                err_o           - sticky ack-timeout error
//                moves_done_o    - completed transfer count (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module move_sequencer #(
   parameter int DW      = 24,
   parameter int AW      = 7,
   parameter int LW      = 12,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic          in_lit_mv_i,
   input  logic [AW-1:0] in_src_i,
   input  logic [AW-1:0] in_dest_i,
   input  logic          in_hl_i,
   input  logic [LW-1:0] in_lit_i,
   output logic          rd_en_o,
   output logic [AW-1:0] rd_addr_o,
   input  logic [DW-1:0] rd_data_i,
   input  logic          rd_ack_i,
   output logic          wr_en_o,
   output logic [AW-1:0] wr_addr_o,
   output logic [DW-1:0] wr_data_o,
   output logic [1:0]    wr_mask_o,
   input  logic          wr_ack_i,
   output logic          err_o,
   output logic [15:0]   moves_done_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   // Counter value seen in the last ack-less cycle that is still tolerated;
   // an ack in that same cycle still completes the transfer.
   localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT - 1);

   state_t          state_q;
   logic [7:0]      tmo_cnt_q;
   logic            rd_en_q;
   logic [AW-1:0]   rd_addr_q;
   logic            wr_en_q;
   logic [AW-1:0]   wr_addr_q;
   logic [DW-1:0]   wr_data_q;
   logic [1:0]      wr_mask_q;
   logic            err_q;
   logic [15:0]     moves_done_q;

   logic            w_accept;

   // Ready in WR only while the current write is being acknowledged, so the
   // next instruction can be taken without an idle bubble.
   assign in_ready_o = (state_q == S_IDLE) | ((state_q == S_WR) & wr_ack_i);
   assign w_accept   = in_valid_i & in_ready_o;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         tmo_cnt_q    <= 8'd0;
         rd_en_q      <= 1'b0;
         rd_addr_q    <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         wr_mask_q    <= 2'b00;
         err_q        <= 1'b0;
         moves_done_q <= 16'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // Stray acks are ignored; acceptance handled below.
            end

            S_RD: begin
               if (rd_ack_i) begin
                  wr_data_q <= rd_data_i;
                  wr_mask_q <= 2'b11;
                  rd_en_q   <= 1'b0;
                  wr_en_q   <= 1'b1;
                  tmo_cnt_q <= 8'd0;
                  state_q   <= S_WR;
               end else if (tmo_cnt_q == c_TIMEOUT_LAST) begin
                  rd_en_q <= 1'b0;
                  err_q   <= 1'b1;
                  state_q <= S_ERR;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 8'd1;
               end
            end

            S_WR: begin
               if (wr_ack_i) begin
                  moves_done_q <= moves_done_q + 16'd1;
                  wr_en_q      <= 1'b0;
                  state_q      <= S_IDLE;
               end else if (tmo_cnt_q == c_TIMEOUT_LAST) begin
                  wr_en_q <= 1'b0;
                  err_q   <= 1'b1;
                  state_q <= S_ERR;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 8'd1;
               end
            end

            S_ERR: begin
               // Sticky until reset.
               rd_en_q <= 1'b0;
               wr_en_q <= 1'b0;
               err_q   <= 1'b1;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase

         // Acceptance overrides the WR-completion defaults above, which is
         // how a back-to-back instruction skips IDLE.
         if (w_accept) begin
            tmo_cnt_q <= 8'd0;
            wr_addr_q <= in_dest_i;
            if (in_lit_mv_i) begin
               wr_data_q <= {in_lit_i, in_lit_i};
               wr_mask_q <= in_hl_i ? 2'b10 : 2'b01;
               rd_en_q   <= 1'b0;
               wr_en_q   <= 1'b1;
               state_q   <= S_WR;
            end else begin
               rd_addr_q <= in_src_i;
               rd_en_q   <= 1'b1;
               wr_en_q   <= 1'b0;
               state_q   <= S_RD;
            end
         end
      end
   end

   assign rd_en_o      = rd_en_q;
   assign rd_addr_o    = rd_addr_q;
   assign wr_en_o      = wr_en_q;
   assign wr_addr_o    = wr_addr_q;
   assign wr_data_o    = wr_data_q;
   assign wr_mask_o    = wr_mask_q;
   assign err_o        = err_q;
   assign moves_done_o = moves_done_q;

endmodule
`default_nettype wire

// File: tb/tb_move_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_move_sequencer
//  Description : Self-checking bench for move_sequencer. A transaction-level
//                model predicts socket strobes, addresses, write data/mask,
//                completion count and error flag for directed and random
//                instruction streams with random ack delays.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_move_sequencer;

   localparam int DW      = 24;
   localparam int AW      = 7;
   localparam int LW      = 12;
   localparam int TIMEOUT = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic          in_lit_mv;
   logic [AW-1:0] in_src;
   logic [AW-1:0] in_dest;
   logic          in_hl;
   logic [LW-1:0] in_lit;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          rd_ack;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [1:0]    wr_mask;
   logic          wr_ack;
   logic          err;
   logic [15:0]   moves_done;

   move_sequencer #(.DW(DW), .AW(AW), .LW(LW), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .in_lit_mv_i  (in_lit_mv),
      .in_src_i     (in_src),
      .in_dest_i    (in_dest),
      .in_hl_i      (in_hl),
      .in_lit_i     (in_lit),
      .rd_en_o      (rd_en),
      .rd_addr_o    (rd_addr),
      .rd_data_i    (rd_data),
      .rd_ack_i     (rd_ack),
      .wr_en_o      (wr_en),
      .wr_addr_o    (wr_addr),
      .wr_data_o    (wr_data),
      .wr_mask_o    (wr_mask),
      .wr_ack_i     (wr_ack),
      .err_o        (err),
      .moves_done_o (moves_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          lit;
      logic [AW-1:0] src;
      logic [AW-1:0] dest;
      logic          hl;
      logic [LW-1:0] val;
   } instr_t;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_done;
   bit          pre_acc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic instr_t mk(input logic lit, input logic [AW-1:0] s, input logic [AW-1:0] d,
                                 input logic hl, input logic [LW-1:0] v);
      instr_t i;
      i.lit = lit; i.src = s; i.dest = d; i.hl = hl; i.val = v;
      return i;
   endfunction

   function automatic instr_t rand_instr();
      return mk(1'($urandom_range(0, 1)), AW'($urandom), AW'($urandom),
                1'($urandom_range(0, 1)), LW'($urandom));
   endfunction

   task automatic drive(input instr_t i, input logic v);
      in_valid  = v;
      in_lit_mv = i.lit;
      in_src    = i.src;
      in_dest   = i.dest;
      in_hl     = i.hl;
      in_lit    = i.val;
   endtask

   task automatic quiet();
      drive(mk(1'b0, '0, '0, 1'b0, '0), 1'b0);
      rd_ack  = 1'b0;
      wr_ack  = 1'b0;
      rd_data = '0;
   endtask

   task automatic do_reset();
      quiet();
      rst = 1'b1;
      step();
      step();
      rst      = 1'b0;
      exp_done = 16'd0;
      pre_acc  = 1'b0;
   endtask

   // One complete transfer. rdly/wdly = ack-less cycles before the ack.
   // b2b presents nx during the write-ack cycle.
   task automatic run_tx(input instr_t cur, input instr_t nx, input int rdly, input int wdly,
                         input bit b2b, input logic [DW-1:0] rdat);
      logic [DW-1:0] edata;
      logic [1:0]    emask;
      bit            last;
      if (!pre_acc) begin
         drive(cur, 1'b1);
         rd_ack = 1'($urandom_range(0, 1));
         wr_ack = 1'($urandom_range(0, 1));
         #1;
         chk("idle_ready", in_ready, 1);
         chk("idle_rd_en", rd_en, 0);
         chk("idle_wr_en", wr_en, 0);
         chk("idle_done", moves_done, exp_done);
         step();
      end
      if (!cur.lit) begin
         for (int k = 0; k <= rdly; k++) begin
            drive(rand_instr(), 1'($urandom_range(0, 1)));
            rd_ack  = (k == rdly);
            rd_data = (k == rdly) ? rdat : DW'($urandom);
            wr_ack  = 1'($urandom_range(0, 1));
            #1;
            chk("rd_en", rd_en, 1);
            chk("rd_addr", rd_addr, cur.src);
            chk("rd_wr_en", wr_en, 0);
            chk("rd_ready", in_ready, 0);
            chk("rd_err", err, 0);
            chk("rd_done", moves_done, exp_done);
            step();
         end
         edata = rdat;
         emask = 2'b11;
      end else begin
         edata = {cur.val, cur.val};
         emask = cur.hl ? 2'b10 : 2'b01;
      end
      for (int k = 0; k <= wdly; k++) begin
         last = (k == wdly);
         if (last && b2b) drive(nx, 1'b1);
         else drive(rand_instr(), last ? 1'b0 : 1'($urandom_range(0, 1)));
         wr_ack  = last;
         rd_ack  = 1'($urandom_range(0, 1));
         rd_data = DW'($urandom);
         #1;
         chk("wr_en", wr_en, 1);
         chk("wr_addr", wr_addr, cur.dest);
         chk("wr_data", wr_data, edata);
         chk("wr_mask", wr_mask, emask);
         chk("wr_rd_en", rd_en, 0);
         chk("wr_ready", in_ready, last);
         chk("wr_err", err, 0);
         chk("wr_done", moves_done, exp_done);
         step();
      end
      exp_done = exp_done + 16'd1;
      pre_acc  = b2b;
      quiet();
   endtask

   // Hold the relevant ack low and expect ERR after TIMEOUT strobe cycles.
   task automatic timeout_case(input instr_t cur);
      drive(cur, 1'b1);
      #1;
      chk("to_idle_ready", in_ready, 1);
      step();
      quiet();
      for (int k = 0; k < TIMEOUT; k++) begin
         #1;
         chk(cur.lit ? "to_wr_en" : "to_rd_en", cur.lit ? wr_en : rd_en, 1);
         chk("to_err_early", err, 0);
         step();
      end
      for (int k = 0; k < 3; k++) begin
         drive(rand_instr(), 1'b1);
         rd_ack = 1'($urandom_range(0, 1));
         wr_ack = 1'($urandom_range(0, 1));
         #1;
         chk("err_flag", err, 1);
         chk("err_rd_en", rd_en, 0);
         chk("err_wr_en", wr_en, 0);
         chk("err_ready", in_ready, 0);
         chk("err_done", moves_done, exp_done);
         step();
      end
      do_reset();
      #1;
      chk("err_cleared", err, 0);
      chk("err_rst_ready", in_ready, 1);
      step();
   endtask

   initial begin
      instr_t cur;
      instr_t nxt;
      int     rd_d;
      int     wd_d;
      bit     b2b;

      quiet();
      rst = 1'b1;
      step();
      // Reset state, sampled while reset is still applied.
      chk("rst_ready", in_ready, 1);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_wr_mask", wr_mask, 0);
      chk("rst_err", err, 0);
      chk("rst_done", moves_done, 0);
      rst      = 1'b0;
      exp_done = 16'd0;
      pre_acc  = 1'b0;

      // Move 0x01 -> 0x7F, read ack after one wait cycle, immediate write ack.
      run_tx(mk(1'b0, 7'h01, 7'h7F, 1'b0, 12'h0), mk(1'b0, '0, '0, 1'b0, '0), 1, 0, 1'b0, 24'hABCDEF);
      // Literal 0xFFF high half -> socket 0x00.
      run_tx(mk(1'b1, 7'h00, 7'h00, 1'b1, 12'hFFF), mk(1'b0, '0, '0, 1'b0, '0), 0, 0, 1'b0, 24'h0);
      // Back-to-back: literal low 0x123 -> 0x05 then move 0x05 -> 0x06.
      run_tx(mk(1'b1, 7'h00, 7'h05, 1'b0, 12'h123), mk(1'b0, 7'h05, 7'h06, 1'b0, 12'h0), 0, 0, 1'b1, 24'h0);
      run_tx(mk(1'b0, 7'h05, 7'h06, 1'b0, 12'h0), mk(1'b0, '0, '0, 1'b0, '0), 0, 0, 1'b0, 24'h123123);
      // src == dest move; acks on the last tolerated cycle.
      run_tx(mk(1'b0, 7'h33, 7'h33, 1'b0, 12'h0), mk(1'b0, '0, '0, 1'b0, '0), TIMEOUT-1, TIMEOUT-1, 1'b0, 24'h5A5A5A);
      run_tx(mk(1'b1, 7'h00, 7'h11, 1'b0, 12'hA5C), mk(1'b0, '0, '0, 1'b0, '0), 0, TIMEOUT-1, 1'b0, 24'h0);

      // Random stream.
      nxt = rand_instr();
      for (int n = 0; n < 60; n++) begin
         cur  = nxt;
         nxt  = rand_instr();
         rd_d = ($urandom_range(0, 7) == 0) ? TIMEOUT-1 : int'($urandom_range(0, 3));
         wd_d = ($urandom_range(0, 7) == 0) ? TIMEOUT-1 : int'($urandom_range(0, 3));
         b2b  = (n < 59) ? 1'($urandom_range(0, 1)) : 1'b0;
         run_tx(cur, nxt, rd_d, wd_d, b2b, DW'($urandom));
      end
      #1;
      chk("rand_final_done", moves_done, exp_done);
      chk("rand_final_ready", in_ready, 1);

      // Reset while a write strobe is active.
      drive(mk(1'b1, 7'h00, 7'h22, 1'b1, 12'h456), 1'b1);
      step();
      quiet();
      rst = 1'b1;
      #1;
      chk("mid_wr_en", wr_en, 1);
      chk("mid_done_pre", moves_done, exp_done);
      step();
      rst      = 1'b0;
      exp_done = 16'd0;
      pre_acc  = 1'b0;
      chk("mid_rst_wr_en", wr_en, 0);
      chk("mid_rst_ready", in_ready, 1);
      chk("mid_rst_done", moves_done, 0);

      // Timeouts on read and on write.
      timeout_case(mk(1'b0, 7'h0A, 7'h0B, 1'b0, 12'h0));
      timeout_case(mk(1'b1, 7'h00, 7'h0C, 1'b1, 12'h777));

      // Counter wrap: continuous literal loads with the write acked every cycle.
      drive(mk(1'b1, 7'h00, 7'h01, 1'b0, 12'h001), 1'b1);
      wr_ack = 1'b1;
      step();
      for (int i = 0; i < 65535; i++) step();
      chk("wrap_ffff", moves_done, 16'hFFFF);
      chk("wrap_wr_en", wr_en, 1);
      in_valid = 1'b0;
      step();
      wr_ack = 1'b0;
      #1;
      chk("wrap_zero", moves_done, 16'h0000);
      chk("wrap_idle_wr_en", wr_en, 0);
      chk("wrap_idle_ready", in_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
